conv_accum: RTL and testbench

- Downstream accumulator for the conv datapath's 8x8 signed multiplier.
- Consumes the multiplier's 16-bit two's-complement products one tap at a time and sums TAPS products (one 3x3 kernel window by default).
- Rounds, rescales and saturates the sum to a signed 8-bit output pixel.
- Output is presented over a valid/ready handshake to the next conv stage (activation / writeback).

---
 rtl/conv_accum.sv | 155 +++++++++++++++
 tb/tb_conv_accum.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_accum.sv
// Accumulates TAPS signed products from the conv multiplier, then rounds, rescales and
// saturates the sum into one signed output pixel presented over a valid/ready handshake.
module conv_accum #(
  parameter int TAPS  = 9,
  parameter int ACC_W = 20,
  parameter int SHIFT = 7,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             prod_valid,
  input  logic [15:0]      prod_data,
  output logic             prod_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  input  logic             out_ready,
  output logic [3:0]       tap_cnt
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } state_t;

  localparam logic [3:0] LAST_TAP = 4'(TAPS - 1);
  // Rounding, clipping bounds: one guard bit above ACC_W so the +half never wraps.
  localparam logic signed [ACC_W:0] RND_C   = {{(ACC_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic signed [ACC_W-1:0] acc_r;
  logic [3:0]              tap_r;
  logic                    out_valid_r;
  logic [OUT_W-1:0]        out_data_r;
  logic                    out_sat_r;

  logic                    ready_s;
  logic                    accept_s;
  logic                    last_s;
  logic                    hs_s;
  logic signed [ACC_W-1:0] prod_sext_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W:0]   rnd_s;
  logic signed [ACC_W:0]   r_s;
  logic                    sat_hi_s;
  logic                    sat_lo_s;
  logic [OUT_W-1:0]        clip_s;

  assign prod_ready = ready_s;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_sat    = out_sat_r;
  assign tap_cnt    = tap_r;

  assign accept_s    = prod_valid & ready_s & ~clear;
  assign last_s      = (tap_r == LAST_TAP);
  assign hs_s        = out_valid_r & out_ready;
  assign prod_sext_s = $signed({{(ACC_W-16){prod_data[15]}}, prod_data});
  assign sum_s       = acc_r + prod_sext_s;
  assign rnd_s       = $signed({sum_s[ACC_W-1], sum_s}) + RND_C;
  assign r_s         = rnd_s >>> SHIFT;
  assign sat_hi_s    = (r_s > SAT_MAX);
  assign sat_lo_s    = (r_s < SAT_MIN);

  // Saturating clip of the rescaled sum to the output range.
  always_comb begin
    clip_s = r_s[OUT_W-1:0];
    if (sat_hi_s) begin
      clip_s = SAT_MAX[OUT_W-1:0];
    end else if (sat_lo_s) begin
      clip_s = SAT_MIN[OUT_W-1:0];
    end else begin
      clip_s = r_s[OUT_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; clear always returns to ACCUM.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = ACCUM;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s && last_s) begin
            state_nxt_s = OUT;
          end else begin
            state_nxt_s = ACCUM;
          end
        end
        OUT: begin
          if (hs_s) begin
            state_nxt_s = ACCUM;
          end else begin
            state_nxt_s = OUT;
          end
        end
        default: state_nxt_s = ACCUM;
      endcase
    end
  end

  // Output decode; ready is forced low while reset is asserted.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ACCUM:   ready_s = rst_n;
      OUT:     ready_s = 1'b0;
      default: ready_s = 1'b0;
    endcase
  end

  // Accumulator, tap counter and registered pixel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= '0;
      tap_r       <= 4'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sat_r   <= 1'b0;
    end else if (clear) begin
      acc_r       <= '0;
      tap_r       <= 4'd0;
      out_valid_r <= 1'b0;
      out_sat_r   <= 1'b0;
    end else if (accept_s && last_s) begin
      acc_r       <= '0;
      tap_r       <= 4'd0;
      out_valid_r <= 1'b1;
      out_data_r  <= clip_s;
      out_sat_r   <= sat_hi_s | sat_lo_s;
    end else if (accept_s) begin
      acc_r <= sum_s;
      tap_r <= tap_r + 4'd1;
    end else if (hs_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_conv_accum.sv
// Directed bench for conv_accum: nominal, rounding, saturation, stalls, abort and async reset.
module tb_conv_accum;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        prod_valid;
  logic [15:0] prod_data;
  logic        prod_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        out_ready;
  logic [3:0]  tap_cnt;

  int total;
  int bad;
  logic signed [15:0] vec [9];

  conv_accum dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_ready  (out_ready),
    .tap_cnt    (tap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fill_vec(input logic signed [15:0] v);
    for (int i = 0; i < 9; i++) vec[i] = v;
  endtask

  // Present vec[0..n-1], one accept per tap; optional random idle gaps with junk data.
  task automatic feed(input int n, input bit gaps);
    int w;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      w = 0;
      while (!prod_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!prod_ready) begin
        total++; bad++;
        $display("FAIL feed_timeout got prod_ready=0 need 1");
      end
      prod_valid = 1'b1;
      prod_data  = vec[i];
      @(posedge clk);
      @(negedge clk);
      prod_valid = 1'b0;
      prod_data  = 16'h7fff;
    end
  endtask

  // Wait for a pixel (bounded) and capture it; completes the handshake if out_ready is high.
  task automatic get_pixel(output logic signed [7:0] pd, output logic ps);
    int w;
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL pixel_timeout got out_valid=0 need 1");
    end
    pd = out_data;
    ps = out_sat;
    if (out_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b need=0", out_valid); end
    total++; if (out_data !== 8'd0) begin bad++; $display("FAIL rst_data got=%0d need=0", out_data); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL rst_sat got=%0b need=0", out_sat); end
    total++; if (tap_cnt !== 4'd0) begin bad++; $display("FAIL rst_tap got=%0d need=0", tap_cnt); end
    total++; if (prod_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b need=0", prod_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (prod_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b need=1", prod_ready); end
  endtask

  task automatic test_nominal;
    int nv;
    int first;
    int second;
    nv = 0; first = -1; second = -1;
    @(negedge clk);
    out_ready  = 1'b1;
    prod_valid = 1'b1;
    prod_data  = 16'd128;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        nv++;
        if (first < 0) first = c; else second = c;
        total++;
        if ($signed(out_data) !== 8'sd9 || out_sat !== 1'b0) begin
          bad++; $display("FAIL nom_data got=%0d/%0b need=9/0", $signed(out_data), out_sat);
        end
      end
    end
    prod_valid = 1'b0;
    total++; if (nv !== 2) begin bad++; $display("FAIL nom_valid_cycles got=%0d need=2", nv); end
    total++; if (first !== 8) begin bad++; $display("FAIL nom_latency got=%0d need=8", first); end
    total++; if (second - first !== 10) begin bad++; $display("FAIL nom_period got=%0d need=10", second - first); end
    total++; if (tap_cnt !== 4'd5) begin bad++; $display("FAIL nom_partial_tap got=%0d need=5", tap_cnt); end
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    total++; if (tap_cnt !== 4'd0) begin bad++; $display("FAIL nom_clear_tap got=%0d need=0", tap_cnt); end
  endtask

  task automatic test_rounding;
    int rv [4] = '{64, -64, -65, 63};
    int re [4] = '{1, 0, -1, 0};
    logic signed [7:0] pd;
    logic ps;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fill_vec(16'sd0);
      vec[k + 2] = 16'(rv[k]);
      feed(9, 1'b0);
      get_pixel(pd, ps);
      total++;
      if (pd !== re[k] || ps !== 1'b0) begin
        bad++; $display("FAIL round_%0d got=%0d/%0b need=%0d/0", rv[k], pd, ps, re[k]);
      end
    end
  endtask

  task automatic test_saturation;
    int sv [3] = '{16384, -16384, 14000};
    int se [3] = '{127, -128, 127};
    logic signed [7:0] pd;
    logic ps;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fill_vec(16'(sv[k]));
      feed(9, 1'b0);
      get_pixel(pd, ps);
      total++;
      if (pd !== se[k] || ps !== 1'b1) begin
        bad++; $display("FAIL sat_%0d got=%0d/%0b need=%0d/1", sv[k], pd, ps, se[k]);
      end
    end
  endtask

  task automatic test_stall;
    logic signed [7:0] pd;
    logic ps;
    out_ready = 1'b0;
    fill_vec(16'sd128);
    feed(9, 1'b0);
    prod_valid = 1'b1;
    prod_data  = 16'd1000;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (out_valid !== 1'b1 || $signed(out_data) !== 8'sd9 || prod_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold_%0d got v=%0b d=%0d r=%0b need 1/9/0", c, out_valid, $signed(out_data), prod_ready);
      end
      @(negedge clk);
    end
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || prod_ready !== 1'b1 || tap_cnt !== 4'd0) begin
      bad++; $display("FAIL stall_release got v=%0b r=%0b t=%0d need 0/1/0", out_valid, prod_ready, tap_cnt);
    end
    vec = '{16'sd1000, -16'sd200, 16'sd300, 16'sd400, -16'sd50, 16'sd0, 16'sd700, -16'sd1500, 16'sd2000};
    feed(9, 1'b1);
    get_pixel(pd, ps);
    total++; if (pd !== 8'sd21 || ps !== 1'b0) begin bad++; $display("FAIL gap_pixel got=%0d/%0b need=21/0", pd, ps); end
  endtask

  task automatic test_abort;
    logic signed [7:0] pd;
    logic ps;
    out_ready = 1'b1;
    fill_vec(16'sd1000);
    feed(4, 1'b0);
    total++; if (tap_cnt !== 4'd4) begin bad++; $display("FAIL abort_pre_tap got=%0d need=4", tap_cnt); end
    prod_valid = 1'b1;
    prod_data  = 16'd5000;
    clear      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear      = 1'b0;
    prod_valid = 1'b0;
    total++; if (tap_cnt !== 4'd0) begin bad++; $display("FAIL abort_tap got=%0d need=0", tap_cnt); end
    fill_vec(16'sd256);
    feed(9, 1'b0);
    get_pixel(pd, ps);
    total++; if (pd !== 8'sd18 || ps !== 1'b0) begin bad++; $display("FAIL abort_pixel got=%0d/%0b need=18/0", pd, ps); end
    // Clear while a saturated pixel waits: valid and sat drop, data is held.
    out_ready = 1'b0;
    fill_vec(16'sd16384);
    feed(9, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_sat !== 1'b0 || out_data !== 8'd127) begin
      bad++; $display("FAIL clear_out got v=%0b s=%0b d=%0d need 0/0/127", out_valid, out_sat, out_data);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_async_reset;
    logic signed [7:0] pd;
    logic ps;
    fill_vec(16'sd1000);
    feed(4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (tap_cnt !== 4'd0 || out_valid !== 1'b0 || out_data !== 8'd0 || out_sat !== 1'b0 || prod_ready !== 1'b0) begin
      bad++; $display("FAIL arst_window got t=%0d v=%0b d=%0d s=%0b r=%0b need all 0", tap_cnt, out_valid, out_data, out_sat, prod_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    fill_vec(16'sd100);
    feed(9, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'd7) begin bad++; $display("FAIL arst_pre_pixel got v=%0b d=%0d need 1/7", out_valid, out_data); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_sat !== 1'b0 || prod_ready !== 1'b0) begin
      bad++; $display("FAIL arst_out got v=%0b d=%0d s=%0b r=%0b need all 0", out_valid, out_data, out_sat, prod_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    fill_vec(-16'sd128);
    feed(9, 1'b0);
    get_pixel(pd, ps);
    total++; if (pd !== -8'sd9 || ps !== 1'b0) begin bad++; $display("FAIL arst_next_pixel got=%0d/%0b need=-9/0", pd, ps); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    clear      = 1'b0;
    prod_valid = 1'b0;
    prod_data  = 16'd0;
    out_ready  = 1'b1;
    test_reset;
    test_nominal;
    test_rounding;
    test_saturation;
    test_stall;
    test_abort;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
